// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
//   Two requesters share one even-parity checker. Round-robin arbitration
//   admits at most one word per cycle into a single registered response slot.
//   The slot can be refilled in the same cycle it is drained. A saturating
//   parity-error count is kept per requester.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   reqN_valid/ready/data/parity requester N handshake, data word, even-parity bit
//   resp_valid/ready             response slot handshake
//   resp_id, resp_data           owner of the response and the echoed data word
//   resp_error                   1 = odd number of ones over {data, parity}
//   clr_cnt                      synchronous clear of both error counters
//   err_cnt0, err_cnt1           saturating per-requester error counts
module parity_check_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_parity,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_parity,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t       state;
  logic              last_grant;
  logic              slot_free;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_parity;
  logic              sel_error;

  always_comb begin
    slot_free = (state == EMPTY) || resp_ready;

    // On contention, favour whoever was not served last.
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant;
    end else begin
      grant1 = req1_valid;
    end

    req0_ready = rst_n && slot_free && req0_valid && !grant1;
    req1_ready = rst_n && slot_free && req1_valid &&  grant1;
    accept     = req0_ready || req1_ready;

    sel_data   = grant1 ? req1_data   : req0_data;
    sel_parity = grant1 ? req1_parity : req0_parity;
    sel_error  = ^{sel_data, sel_parity};
  end

  assign resp_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      err_cnt0   <= '0;
      err_cnt1   <= '0;
    end else begin
      // An accept always refills the slot; this covers both the empty case and
      // the drain-and-refill case, so there is no bubble between responses.
      if (accept) begin
        state      <= FULL;
        resp_id    <= grant1;
        resp_data  <= sel_data;
        resp_error <= sel_error;
        last_grant <= grant1;
      end else if (resp_ready) begin
        state <= EMPTY;
      end

      if (clr_cnt) begin
        err_cnt0 <= '0;
        err_cnt1 <= '0;
      end else if (accept && sel_error) begin
        if (grant1) begin
          if (err_cnt1 != '1) err_cnt1 <= err_cnt1 + CNT_W'(1);
        end else begin
          if (err_cnt0 != '1) err_cnt0 <= err_cnt0 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_check_arbiter.sv
module tb_parity_check_arbiter;

  localparam int DW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_parity;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_ready, req1_parity;
  logic [DW-1:0] req1_data;
  logic          resp_valid, resp_ready, resp_id, resp_error;
  logic [DW-1:0] resp_data;
  logic          clr_cnt;
  logic [CW-1:0] err_cnt0, err_cnt1;

  parity_check_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_parity(req0_parity),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_parity(req1_parity),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_error(resp_error),
    .clr_cnt(clr_cnt), .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  typedef struct {
    logic v0; logic [DW-1:0] d0; logic p0;
    logic v1; logic [DW-1:0] d1; logic p1;
    logic rr; logic clr;
    logic er0; logic er1; logic eerr; int ec0; int ec1;
  } vec_t;

  resp_t q[$];
  int    m_cnt0, m_cnt1;
  logic  m_last;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic p0,
                       input logic v1, input logic [DW-1:0] d1, input logic p1,
                       input logic rr, input logic clr);
    req0_valid = v0; req0_data = d0; req0_parity = p0;
    req1_valid = v1; req1_data = d1; req1_parity = p1;
    resp_ready = rr; clr_cnt = clr;
  endtask

  // One clock: check readies against the model before the edge, advance the
  // model at the edge, then check the response slot and counters after it.
  task automatic cycle();
    logic  free, g1, a0, a1;
    resp_t r;
    #1;
    free = (q.size() == 0) || resp_ready;
    if (req0_valid && req1_valid) g1 = !m_last;
    else                          g1 = req1_valid;
    a0 = rst_n && free && req0_valid && !g1;
    a1 = rst_n && free && req1_valid &&  g1;
    r.id   = a1;
    r.data = a1 ? req1_data : req0_data;
    r.err  = a1 ? ^{req1_data, req1_parity} : ^{req0_data, req0_parity};
    chk("req0_ready", 32'(req0_ready), 32'(a0));
    chk("req1_ready", 32'(req1_ready), 32'(a1));
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_cnt0 = 0; m_cnt1 = 0; m_last = 1'b1;
    end else begin
      if (q.size() != 0 && resp_ready) void'(q.pop_front());
      if (a0 || a1) begin
        q.push_back(r);
        m_last = a1;
        if (r.err) begin
          if (a1) m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
          else    m_cnt0 = (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
        end
      end
      if (clr_cnt) begin m_cnt0 = 0; m_cnt1 = 0; end
    end
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("resp_id",    32'(resp_id),    32'(q[0].id));
      chk("resp_data",  32'(resp_data),  32'(q[0].data));
      chk("resp_error", 32'(resp_error), 32'(q[0].err));
    end
    chk("err_cnt0", 32'(err_cnt0), 32'(m_cnt0));
    chk("err_cnt1", 32'(err_cnt1), 32'(m_cnt1));
  endtask

  vec_t tbl[9];

  initial begin
    //            v0 d0       p0 v1 d1       p1 rr clr er0 er1 eerr c0 c1
    tbl[0] = '{1, 4'b1011, 1, 0, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 4'b0000, 0, 1, 4'b0000, 1, 1, 0, 0, 1, 1, 0, 1};
    tbl[2] = '{0, 4'b0000, 0, 1, 4'b1100, 1, 1, 0, 0, 1, 1, 0, 2};
    tbl[3] = '{0, 4'b0000, 0, 1, 4'b1111, 0, 1, 0, 0, 1, 0, 0, 2};
    tbl[4] = '{1, 4'b0001, 0, 1, 4'b0011, 0, 1, 0, 1, 0, 1, 1, 2};
    tbl[5] = '{1, 4'b0001, 0, 1, 4'b0111, 0, 1, 0, 0, 1, 1, 1, 3};
    tbl[6] = '{0, 4'b0000, 0, 1, 4'b0001, 0, 1, 0, 0, 1, 1, 1, 3};
    tbl[7] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 1, 3};
    tbl[8] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0};

    m_cnt0 = 0; m_cnt1 = 0; m_last = 1'b1;
    drive(1, 4'hF, 0, 1, 4'hF, 0, 1, 0);
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_resp_data",  32'(resp_data),  32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].p0, tbl[i].v1, tbl[i].d1, tbl[i].p1,
            tbl[i].rr, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d_r0", i), 32'(req0_ready), 32'(tbl[i].er0));
      chk($sformatf("vec%0d_r1", i), 32'(req1_ready), 32'(tbl[i].er1));
      cycle();
      if (tbl[i].er0 || tbl[i].er1)
        chk($sformatf("vec%0d_err", i), 32'(resp_error), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_c0", i), 32'(err_cnt0), 32'(tbl[i].ec0));
      chk($sformatf("vec%0d_c1", i), 32'(err_cnt1), 32'(tbl[i].ec1));
    end

    // Contention straight after reset: strict alternation starting with 0.
    rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 1, 0); cycle(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'($urandom), 1'($urandom), 1, 4'($urandom), 1'($urandom), 1, 0);
      #1;
      chk("cont_r0", 32'(req0_ready), 32'(i % 2 == 0));
      cycle();
      chk("cont_valid", 32'(resp_valid), 32'd1);
      chk("cont_id", 32'(resp_id), 32'(i % 2));
    end

    // Backpressure with the slot full: nothing accepted, contents held.
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'($urandom), 1'($urandom), 1, 4'($urandom), 1'($urandom), 0, 0);
      #1;
      chk("bp_r0", 32'(req0_ready), 32'd0);
      chk("bp_r1", 32'(req1_ready), 32'd0);
      cycle();
    end
    drive(1, 4'b0110, 0, 1, 4'b1001, 1, 1, 0);
    #1;
    chk("bp_release_r0", 32'(req0_ready), 32'd1);
    cycle();
    chk("bp_release_id", 32'(resp_id), 32'd0);

    // Saturation and clear-over-increment.
    rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 1, 0); cycle(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0001, 0, 0, 0, 0, 1, 0);
      cycle();
      chk("sat_cnt0", 32'(err_cnt0), 32'((i + 1 < CMAX) ? i + 1 : CMAX));
    end
    drive(1, 4'b0001, 0, 0, 0, 0, 1, 1);
    cycle();
    chk("clr_cnt0", 32'(err_cnt0), 32'd0);

    // Reset while full and backpressured.
    drive(1, 4'b0111, 0, 0, 0, 0, 0, 0);
    cycle();
    rst_n = 1'b0;
    drive(1, 4'b0011, 0, 1, 4'b0101, 0, 0, 0);
    cycle();
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_cnt0",  32'(err_cnt0),   32'd0);
    rst_n = 1'b1;
    drive(1, 4'b0011, 0, 1, 4'b0101, 0, 1, 0);
    #1;
    chk("midrst_r0", 32'(req0_ready), 32'd1);
    chk("midrst_r1", 32'(req1_ready), 32'd0);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_check_arbiter.md
Name: parity_check_arbiter

Overview:
- Shares one even-parity check datapath between two requesters (e.g. two nibble sources), with valid/ready on each request port.
- Round-robin arbitration; one check accepted per cycle.
- Result held in a single registered response slot with backpressure.
- Keeps a saturating parity-error count per requester, used as status and alarm counters beside the parity checkers.

Parameters:
- DATA_W, 4, width of the data word checked (parity bit is separate).
- CNT_W, 8, width of each per-requester error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 has a word to check.
- req0_ready  output  1  requester 0 word accepted this cycle when valid&ready.
- req0_data  input  DATA_W  requester 0 data.
- req0_parity  input  1  requester 0 even-parity bit.
- req1_valid, req1_ready, req1_data, req1_parity: same as above, for requester 1.
- resp_valid  output  1  response slot holds a result.
- resp_ready  input  1  consumer takes the response when valid&ready.
- resp_id  output  1  requester that owns the response (0/1).
- resp_data  output  DATA_W  echoed data word.
- resp_error  output  1  1 = parity violation (odd count of ones over data+parity).
- clr_cnt  input  1  synchronous clear of both error counters.
- err_cnt0  output  CNT_W  requester 0 error count, saturating.
- err_cnt1  output  CNT_W  requester 1 error count, saturating.

Behaviour:
- Check function: error = XOR-reduce of {data, parity}. Even parity means error=0 when the total count of ones is even.
- Slot state machine, two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
  - slot_free = EMPTY, or FULL && resp_ready.
- Ready generation (combinational):
  - At most one ready is high per cycle.
  - reqN_ready = slot_free && reqN_valid && granted(N).
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the one that is not last_grant.
  - last_grant updates only on an actual accept.
- Accept (valid&ready on either port), registered at the next edge:
  - resp_valid<=1; resp_id<=N; resp_data<=data; resp_error<=check.
  - Latency is 1 cycle, request accept to resp_valid.
- Transitions:
  - FULL && resp_ready && no accept: go to EMPTY (resp_valid<=0).
  - FULL && resp_ready && accept: stay FULL with the new contents. No bubble, so full throughput is 1 check/cycle.
  - FULL && !resp_ready: both ready low; resp_id, resp_data and resp_error held stable.
- Counters:
  - On accept with check=1, err_cntN increments.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Counters update at accept time, independent of the response being consumed.
  - clr_cnt=1 sets both counters to 0 on that edge. Clear wins over a same-cycle increment (result 0).
- Reset (rst_n=0 at an edge):
  - resp_valid=0, resp_id=0, resp_data=0, resp_error=0.
  - err_cnt0=0, err_cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Ready outputs are forced 0 while rst_n=0.
  - Reset mid-FULL discards the pending response. Requests presented during reset are not accepted.
- No X-propagation on outputs after the first reset edge. Behaviour before the first reset is undefined.

Test Plan:
- Single request: req0 data=1011, parity=1, resp_ready=1 -> req0_ready=1 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=1011, resp_error=0; err_cnt0=0.
- Error path: req1 data=0000, parity=1 -> resp_id=1, resp_error=1, err_cnt1=1. Then req1 data=1100, parity=1 -> resp_error=1, err_cnt1=2. Then data=1111, parity=0 -> resp_error=0, err_cnt1 stays 2.
- Contention after reset: both valid continuously, resp_ready=1 for 6 cycles -> accepts alternate 0,1,0,1,0,1 (requester 0 first); resp_valid stays high with no bubble.
- Backpressure: response FULL, resp_ready=0 for 3 cycles with both requesters valid -> req0_ready=req1_ready=0 and resp_* fields stable. Raising resp_ready -> accept in that same cycle; new result at the next edge.
- Saturation/clear with CNT_W=2: five erroring req0 words -> err_cnt0 = 1,2,3,3,3. Then clr_cnt=1 together with another erroring accept -> err_cnt0=0.
- Reset mid-operation: rst_n=0 while FULL with resp_ready=0 -> next edge resp_valid=0 and counters 0. After release, both valid -> requester 0 granted first.
